// File: rtl/demux_rr_dispatch_pkg.sv
// Shared encodings and helpers for the round-robin demux feeder.
package demux_rr_dispatch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_FIX = 1'b1;

    localparam int unsigned NCH = 4;

    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return ch + 2'd1;
    endfunction

endpackage

// File: rtl/demux_rr_dispatch_timeout_ctr.sv
// Wait counter for a held word; strobes expire on the last cycle of the window.
module dispatch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MAX  = '1;

    logic [CW-1:0] wcnt;

    // Saturates so fixed-mode and disabled-timeout waits never wrap into a false expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (clear) begin
            wcnt <= '0;
        end else if (enable && (wcnt != MAX)) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    assign expire = (TIMEOUT != 0) && enable && (wcnt == LAST);

endmodule

// File: rtl/demux_rr_dispatch.sv
// Single-word valid/ready holding stage feeding a 1-to-4 demux, with
// round-robin or fixed targeting and timeout retargeting around stalled channels.
module demux_rr_dispatch
    import demux_rr_dispatch_pkg::*;
#(
    parameter int unsigned W       = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           mode,
    input  logic [1:0]     fix_sel,
    input  logic [NCH-1:0] ch_ready,
    output logic [W-1:0]   dmx_in,
    output logic [1:0]     dmx_sel,
    output logic           dmx_valid,
    output logic           skip_pulse
);

    state_t       state, state_n;
    logic [W-1:0] data_n;
    logic [1:0]   sel_n;
    logic [1:0]   ptr, ptr_n, ptr_eff;
    logic         mode_q, mode_n;
    logic         skip_n;
    logic         fire, accept, enable, expire, retarget, clear;

    assign fire      = (state == HOLD) && ch_ready[dmx_sel];
    assign in_ready  = (state == IDLE) || fire;
    assign accept    = in_valid && in_ready;
    assign enable    = (state == HOLD) && !fire;
    assign retarget  = expire && (mode_q == MODE_RR);
    assign clear     = accept || retarget;
    assign dmx_valid = (state == HOLD);

    dispatch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .enable (enable),
        .expire (expire)
    );

    always_comb begin
        state_n = state;
        data_n  = dmx_in;
        sel_n   = dmx_sel;
        ptr_n   = ptr;
        ptr_eff = ptr;
        mode_n  = mode_q;
        skip_n  = 1'b0;

        // A back-to-back accept must see the pointer already advanced past the firing channel.
        if (fire) begin
            ptr_n   = next_ch(dmx_sel);
            ptr_eff = ptr_n;
        end

        if (accept) begin
            state_n = HOLD;
            data_n  = in_data;
            sel_n   = (mode == MODE_FIX) ? fix_sel : ptr_eff;
            mode_n  = mode;
        end else if (fire) begin
            state_n = IDLE;
            data_n  = '0;
        end else if (retarget) begin
            sel_n  = next_ch(dmx_sel);
            skip_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dmx_in     <= '0;
            dmx_sel    <= '0;
            ptr        <= '0;
            mode_q     <= MODE_RR;
            skip_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            dmx_in     <= data_n;
            dmx_sel    <= sel_n;
            ptr        <= ptr_n;
            mode_q     <= mode_n;
            skip_pulse <= skip_n;
        end
    end

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Scoreboarded bench for demux_rr_dispatch: expected {sel,data} pushed on drive, popped on fire.
module tb_demux_rr_dispatch;

    localparam int W       = 4;
    localparam int TIMEOUT = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [1:0]   fix_sel;
    logic [3:0]   ch_ready;
    logic [W-1:0] dmx_in;
    logic [1:0]   dmx_sel;
    logic         dmx_valid;
    logic         skip_pulse;

    int compared   = 0;
    int mismatched = 0;
    int tb_ptr     = 0;

    logic [5:0] sbq[$];
    logic [5:0] sb_exp;

    demux_rr_dispatch #(
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .fix_sel    (fix_sel),
        .ch_ready   (ch_ready),
        .dmx_in     (dmx_in),
        .dmx_sel    (dmx_sel),
        .dmx_valid  (dmx_valid),
        .skip_pulse (skip_pulse)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every handshake on the demux side must match the next queued word.
    always @(negedge clk) begin
        if (!rst && dmx_valid && ch_ready[dmx_sel]) begin
            compared++;
            if (sbq.size() == 0) begin
                mismatched++;
                $display("FAIL sb_unexpected: got sel=%0d data=%h, required no output", dmx_sel, dmx_in);
            end else begin
                sb_exp = sbq.pop_front();
                if ({dmx_sel, dmx_in} !== sb_exp) begin
                    mismatched++;
                    $display("FAIL sb_word: got sel=%0d data=%h, required sel=%0d data=%h",
                             dmx_sel, dmx_in, sb_exp[5:4], sb_exp[3:0]);
                end
            end
        end
        if (!dmx_valid) begin
            compared++;
            if (dmx_in !== '0) begin
                mismatched++;
                $display("FAIL idle_zero: got dmx_in=%h, required 0", dmx_in);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        mode = 1'b0; fix_sel = 2'd0; ch_ready = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({in_ready, dmx_valid, dmx_in, dmx_sel, skip_pulse} !== {1'b1, 1'b0, 4'h0, 2'd0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state: got rdy=%b v=%b d=%h s=%0d sk=%b, required 1 0 0 0 0",
                     in_ready, dmx_valid, dmx_in, dmx_sel, skip_pulse);
        end
        @(posedge clk); #1;
        rst = 1'b0; mode = 1'b1; fix_sel = 2'd2; in_data = 4'hA; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        compared++;
        if ({dmx_valid, dmx_sel, dmx_in} !== {1'b1, 2'd2, 4'hA}) begin
            mismatched++;
            $display("FAIL reset_hold_setup: got v=%b s=%0d d=%h, required 1 2 a", dmx_valid, dmx_sel, dmx_in);
        end
        #1 rst = 1'b1;
        #1;
        compared++;
        if ({dmx_valid, dmx_in, dmx_sel, in_ready} !== {1'b0, 4'h0, 2'd0, 1'b1}) begin
            mismatched++;
            $display("FAIL reset_async: got v=%b d=%h s=%0d rdy=%b, required 0 0 0 1",
                     dmx_valid, dmx_in, dmx_sel, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0; mode = 1'b0;
        tb_ptr = 0;
    endtask

    task automatic test_rr_b2b();
        mode = 1'b0; ch_ready = 4'hF;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            in_data = W'(i); in_valid = 1'b1;
            sbq.push_back({2'(tb_ptr), 4'(i)});
            tb_ptr = (tb_ptr + 1) % 4;
            @(negedge clk);
            compared++;
            if (in_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL rr_ready: got in_ready=%b, required 1 (word %0d)", in_ready, i);
            end
            if (i > 1) begin
                compared++;
                if ({dmx_valid, dmx_in} !== {1'b1, 4'(i - 1)}) begin
                    mismatched++;
                    $display("FAIL rr_no_bubble: got v=%b d=%h, required 1 %h", dmx_valid, dmx_in, 4'(i - 1));
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_fixed();
        ch_ready = 4'hF;
        @(posedge clk); #1;
        mode = 1'b1; fix_sel = 2'd2; in_data = 4'h6; in_valid = 1'b1;
        sbq.push_back({2'd2, 4'h6});
        @(posedge clk); #1;
        in_data = 4'h7;
        sbq.push_back({2'd2, 4'h7});
        tb_ptr = 3;
        @(posedge clk); #1;
        mode = 1'b0; in_data = 4'h8;
        sbq.push_back({2'(tb_ptr), 4'h8});
        tb_ptr = (tb_ptr + 1) % 4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        compared++;
        if ({dmx_valid, dmx_sel} !== {1'b1, 2'd3}) begin
            mismatched++;
            $display("FAIL fixed_then_rr: got v=%b s=%0d, required 1 3", dmx_valid, dmx_sel);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_timeout();
        mode = 1'b0; ch_ready = 4'b1110;
        @(posedge clk); #1;
        in_data = 4'h9; in_valid = 1'b1;
        sbq.push_back({2'd1, 4'h9});
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            compared++;
            if ({dmx_valid, dmx_sel, skip_pulse, in_ready} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
                mismatched++;
                $display("FAIL timeout_wait: cycle %0d got v=%b s=%0d sk=%b rdy=%b, required 1 0 0 0",
                         k, dmx_valid, dmx_sel, skip_pulse, in_ready);
            end
        end
        @(negedge clk);
        compared++;
        if ({dmx_valid, dmx_sel, skip_pulse} !== {1'b1, 2'd1, 1'b1}) begin
            mismatched++;
            $display("FAIL timeout_retarget: got v=%b s=%0d sk=%b, required 1 1 1", dmx_valid, dmx_sel, skip_pulse);
        end
        @(negedge clk);
        compared++;
        if ({dmx_valid, skip_pulse} !== {1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL timeout_after: got v=%b sk=%b, required 0 0", dmx_valid, skip_pulse);
        end
        tb_ptr = 2;
    endtask

    task automatic test_fixed_stall();
        ch_ready = 4'b1110;
        @(posedge clk); #1;
        mode = 1'b1; fix_sel = 2'd0; in_data = 4'hB; in_valid = 1'b1;
        sbq.push_back({2'd0, 4'hB});
        @(posedge clk); #1;
        // Live mode/fix_sel change must not affect the held word; the next word
        // is accepted in round-robin with the pointer advanced past ch0.
        in_data = 4'hC; mode = 1'b0; fix_sel = 2'd3;
        sbq.push_back({2'd1, 4'hC});
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            compared++;
            if ({dmx_sel, skip_pulse, in_ready} !== {2'd0, 1'b0, 1'b0}) begin
                mismatched++;
                $display("FAIL fixed_stall: cycle %0d got s=%0d sk=%b rdy=%b, required 0 0 0",
                         k, dmx_sel, skip_pulse, in_ready);
            end
        end
        @(posedge clk); #1;
        ch_ready = 4'hF;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_release: got in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        compared++;
        if ({dmx_valid, dmx_in} !== {1'b0, 4'h0}) begin
            mismatched++;
            $display("FAIL stall_idle: got v=%b d=%h, required 0 0", dmx_valid, dmx_in);
        end
        tb_ptr = 2;
    endtask

    task automatic test_idle_gap();
        mode = 1'b0; ch_ready = 4'hF;
        @(posedge clk); #1;
        in_data = 4'h3; in_valid = 1'b1;
        sbq.push_back({2'(tb_ptr), 4'h3});
        tb_ptr = (tb_ptr + 1) % 4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        compared++;
        if ({dmx_valid, dmx_in} !== {1'b1, 4'h3}) begin
            mismatched++;
            $display("FAIL gap_word: got v=%b d=%h, required 1 3", dmx_valid, dmx_in);
        end
        @(negedge clk);
        compared++;
        if ({dmx_valid, dmx_in} !== {1'b0, 4'h0}) begin
            mismatched++;
            $display("FAIL gap_idle: got v=%b d=%h, required 0 0", dmx_valid, dmx_in);
        end
    endtask

    initial begin
        test_reset();
        test_rr_b2b();
        test_fixed();
        test_timeout();
        test_fixed_stall();
        test_idle_gap();
        for (int k = 0; k < 20 && sbq.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        compared++;
        if (sbq.size() !== 0) begin
            mismatched++;
            $display("FAIL sb_drain: got %0d words outstanding, required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
